// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// States are plain logic constants so the encoding stays visible in waveforms.
package mips_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int INSTR_W    = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RECV  = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_FIN   = 3'd3;
  localparam state_t ST_CHK   = 3'd4;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler: the first byte of each group of four ends
// up in the most significant lane. o_word_valid flags the byte completing a word.
module byte_packer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_byte_valid,
  input  logic [BYTE_W-1:0]  i_byte,
  output logic [INSTR_W-1:0] o_word,
  output logic               o_word_valid
);

  logic [1:0]         r_cnt;
  logic [INSTR_W-1:0] r_word;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // reset in the sensitivity list, so reset acts without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_byte_valid) begin
      r_word <= {r_word[INSTR_W-BYTE_W-1:0], i_byte};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = i_byte_valid && (r_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: fills instruction memory from word 0, stalls the
// CPU meanwhile and pulses pc_clear at the end. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module imem_loader
  import mips_pkg::*;
#(
  parameter int IM_DEPTH = 256,
  parameter int ADDR_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    word_count,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_hold,
  output logic               pc_clear,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(IM_DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [ADDR_W-1:0]   r_last_idx;
  logic                r_err;

  logic                w_accept;
  logic                w_start;
  logic                w_too_big;
  logic                w_go;
  logic                w_last;
  logic                w_pack_valid;
  logic                w_word_valid;
  logic [INSTR_W-1:0]  w_word;

  assign w_accept     = rx_valid && rx_ready;
  assign w_start      = start && (r_state == ST_IDLE);
  assign w_too_big    = word_count > DEPTH_L;
  assign w_go         = w_start && !w_too_big;
  assign w_last       = (r_word_idx == r_last_idx);
  assign w_pack_valid = w_accept && (r_state == ST_RECV);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_go),
    .i_byte_valid (w_pack_valid),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_xsum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xsum <= '0;
    end else if (w_go) begin
      r_xsum <= '0;
    end else if (w_pack_valid) begin
      r_xsum <= r_xsum ^ rx_data;
    end
  end
`endif

  // Only the count's last index is kept; a zero count bypasses RECV entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_last_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (w_too_big) begin
              r_err <= 1'b1;
            end else begin
              r_err      <= 1'b0;
              r_word_idx <= '0;
              r_last_idx <= ADDR_W'(word_count - ONE_L);
              r_state    <= (word_count == '0) ? ST_FIN : ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (w_word_valid) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state <= ST_CHK;
`else
            r_state <= ST_FIN;
`endif
          end else begin
            r_word_idx <= r_word_idx + 1'b1;
            r_state    <= ST_RECV;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (w_accept) begin
            if (rx_data != r_xsum) r_err <= 1'b1;
            r_state <= ST_FIN;
          end
        end
`endif
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: outputs are continuous functions of registered state, so every
  // path is assigned and no latch can be inferred.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign rx_ready = (r_state == ST_RECV) || (r_state == ST_CHK);
`else
  assign rx_ready = (r_state == ST_RECV);
`endif
  assign im_we    = (r_state == ST_WRITE);
  assign im_addr  = r_word_idx;
  assign im_wdata = w_word;
  assign busy     = (r_state != ST_IDLE);
  assign cpu_hold = busy;
  assign pc_clear = (r_state == ST_FIN);
  assign done     = (r_state == ST_FIN) && !r_err;
  assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, stalls, bounds, reset and busy-start.
// Checksum vectors run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  import mips_pkg::*;

  localparam int IM_DEPTH = 256;
  localparam int ADDR_W   = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_W:0]    word_count;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               im_we;
  logic [ADDR_W-1:0]  im_addr;
  logic [31:0]        im_wdata;
  logic               cpu_hold;
  logic               pc_clear;
  logic               busy;
  logic               done;
  logic               err;

  imem_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .pc_clear   (pc_clear),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0]        pay [16];
  logic [7:0]        stream [20];
  int                chk_byte;
  int                wr_n;
  logic [ADDR_W-1:0] wr_addr [8];
  logic [31:0]       wr_data [8];
  int                fin_cyc;
  int                first_we_idx;
  logic              done_at_fin;
  logic              ready_in_we;
  logic              hold_gap;
  logic              busy_seen;

  // Cycle c is sampled at the c-th falling edge after the edge that takes start.
  task automatic do_load(input logic [ADDR_W:0] wc, input int n_pay, input int mode,
                         input int stop_at, input int busy_start_cyc, input int budget);
    int   idx;
    int   len;
    logic fire;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n_pay; i++) begin
      stream[i] = pay[i];
      x = x ^ pay[i];
    end
    len = n_pay + CHK_EXTRA;
    if (CHK_EXTRA != 0) stream[n_pay] = (chk_byte < 0) ? x : chk_byte[7:0];
    wr_n = 0; fin_cyc = -1; first_we_idx = -1;
    done_at_fin = 1'b0; ready_in_we = 1'b0; hold_gap = 1'b0; busy_seen = 1'b0;
    idx = 0; fire = 1'b0;
    @(negedge clk);
    start = 1'b1; word_count = wc; rx_valid = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      word_count = '0;
      if (fire) idx++;
      if (stop_at >= 0 && idx == stop_at) begin
        rx_valid = 1'b0;
        break;
      end
      if (c == busy_start_cyc) begin
        start = 1'b1;
        word_count = 9'd3;
      end
      if (im_we) begin
        if (wr_n < 8) begin
          wr_addr[wr_n] = im_addr;
          wr_data[wr_n] = im_wdata;
        end
        wr_n++;
        if (rx_ready) ready_in_we = 1'b1;
        if (first_we_idx < 0) first_we_idx = idx;
      end
      if (!cpu_hold) hold_gap = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (pc_clear) begin
        fin_cyc = c;
        done_at_fin = done;
        rx_valid = 1'b0;
        break;
      end
      rx_valid = (idx < len) && (mode == 0 || ((c - 1) % 3) == 0);
      rx_data  = rx_valid ? stream[idx] : 8'h00;
      fire     = rx_valid && rx_ready;
    end
    rx_valid = 1'b0;
  endtask

  task automatic set_word(input logic [31:0] w);
    pay[0] = w[31:24]; pay[1] = w[23:16]; pay[2] = w[15:8]; pay[3] = w[7:0];
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word_count = '0; rx_data = 8'h00; rx_valid = 1'b0;
    chk_byte = -1;
    #12;
    check("reset_ctrl", {rx_ready, im_we, cpu_hold, pc_clear, busy, done, err}, 7'd0);
    check("reset_addr", im_addr, 0);
    check("reset_wdata", im_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // Two words, continuous valid.
    set_word(32'h20080005);
    pay[4] = 8'h01; pay[5] = 8'h09; pay[6] = 8'h50; pay[7] = 8'h20;
    do_load(9'd2, 8, 0, -1, -1, 40);
    check("t1_wr_n", wr_n, 2);
    check("t1_addr0", wr_addr[0], 0);
    check("t1_data0", wr_data[0], 32'h20080005);
    check("t1_addr1", wr_addr[1], 1);
    check("t1_data1", wr_data[1], 32'h01095020);
    check("t1_fin_cyc", fin_cyc, 11 + CHK_EXTRA);
    check("t1_done", done_at_fin, 1'b1);
    check("t1_hold_gap", hold_gap, 1'b0);
    @(negedge clk);
    check("t1_idle_hold", {cpu_hold, busy, pc_clear, done}, 4'd0);

    // Stalled source: valid 1,0,0,1,...
    set_word(32'h8CA40010);
    do_load(9'd1, 4, 1, -1, -1, 60);
    check("t2_wr_n", wr_n, 1);
    check("t2_data", wr_data[0], 32'h8CA40010);
    check("t2_addr", wr_addr[0], 0);
    check("t2_first_we_bytes", first_we_idx, 4);
    check("t2_ready_in_we", ready_in_we, 1'b0);
    if (CHK_EXTRA == 0) check("t2_fin_cyc", fin_cyc, 12);
    else check("t2_fin_cyc", fin_cyc, 14);

    // Oversize count: error, no activity.
    do_load(9'd257, 0, 0, -1, -1, 4);
    check("big_fin", fin_cyc, -1);
    check("big_wr_n", wr_n, 0);
    check("big_busy", busy_seen, 1'b0);
    check("big_err", err, 1'b1);

    // Zero count: straight to FIN, and the accepted start clears err.
    do_load(9'd0, 0, 0, -1, -1, 4);
    check("zero_fin_cyc", fin_cyc, 1);
    check("zero_done", done_at_fin, 1'b1);
    check("zero_wr_n", wr_n, 0);
    check("zero_err", err, 1'b0);

    // Start during RECV with a different count is ignored.
    set_word(32'h8CA40010);
    do_load(9'd1, 4, 0, -1, 2, 40);
    check("busy_wr_n", wr_n, 1);
    check("busy_fin_cyc", fin_cyc, 6 + CHK_EXTRA);
    @(negedge clk);
    check("busy_idle", busy, 1'b0);

    // Asynchronous reset after six bytes of a three-word load.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    pay[4] = 8'h55; pay[5] = 8'h66; pay[6] = 8'h77; pay[7] = 8'h88;
    pay[8] = 8'h99; pay[9] = 8'hAA; pay[10] = 8'hBB; pay[11] = 8'hCC;
    do_load(9'd3, 12, 0, 6, -1, 40);
    check("mid_busy_pre", {busy, im_addr}, {1'b1, 8'd1});
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ctrl", {rx_ready, im_we, cpu_hold, pc_clear, busy, done, err}, 7'd0);
    check("mid_rst_addr", im_addr, 0);
    check("mid_rst_wdata", im_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    set_word(32'hAFBF0004);
    do_load(9'd1, 4, 0, -1, -1, 40);
    check("post_rst_wr_n", wr_n, 1);
    check("post_rst_addr", wr_addr[0], 0);
    check("post_rst_data", wr_data[0], 32'hAFBF0004);
    check("post_rst_done", done_at_fin, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    set_word(32'h00000000);
    chk_byte = 8'h00;
    do_load(9'd1, 4, 0, -1, -1, 40);
    check("cks_ok_done", done_at_fin, 1'b1);
    check("cks_ok_err", err, 1'b0);
    chk_byte = 8'hFF;
    do_load(9'd1, 4, 0, -1, -1, 40);
    check("cks_bad_fin", fin_cyc, 7);
    check("cks_bad_done", done_at_fin, 1'b0);
    check("cks_bad_err", err, 1'b1);
    chk_byte = -1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
